// File: rtl/uart_pkg.sv
// Shared UART definitions: data widths and the serial FSM state encoding used by
// both the receive and transmit channels.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int UART_BAUD_W = 15;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uartState_e;
endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for an asynchronous input pin; both flops reset to RST_VAL
// so an idle-high line never shows a spurious edge when reset is released.
module pin_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_pin
);
  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta  <= RST_VAL;
      o_pin <= RST_VAL;
    end else begin
      meta  <= i_pin;
      o_pin <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receive channel: start-bit validation, mid-bit sampling, one-byte buffer,
// receive interrupt and sticky frame/overrun flags.
module uart_rx
  import uart_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pinRX,
  input  logic                   i_enable,
  input  logic [UART_BAUD_W-1:0] i_baud,
  input  logic                   i_rdAck,
  input  logic                   i_errClr,
  input  logic                   i_smStartPause,
  output logic [UART_BYTE_W-1:0] o_rxByte,
  output logic                   o_rxFull,
  output logic                   o_rxIdle,
  output logic                   o_errFrame,
  output logic                   o_errOverrun,
  output logic                   o_intURX,
  output logic                   o_smNowPaused
);
  uartState_e state, stateNext;

  logic                   rxSync, rxPrev, fallEdge;
  logic [UART_BAUD_W-1:0] bRate;
  logic [15:0]            cnt;
  logic [2:0]             bitIdx;
  logic [UART_BYTE_W-1:0] shReg;
  logic                   halfHit, fullHit;
  logic                   startGo, bitTick, stopTick;
  logic                   canLoad;

  pin_sync #(.RST_VAL(1'b1)) uSync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_pin (i_pinRX),
    .o_pin (rxSync)
  );

  assign fallEdge = rxPrev & ~rxSync;
  // bRate >= 1 whenever these matter, so neither subtraction underflows
  assign halfHit  = (cnt == ({1'b0, bRate} - 16'd1));
  assign fullHit  = (cnt == ({bRate, 1'b0} - 16'd1));
  assign canLoad  = ~o_rxFull | i_rdAck;
  assign o_rxIdle = (state == UART_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= UART_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startGo   = 1'b0;
    bitTick   = 1'b0;
    stopTick  = 1'b0;
    case (state)
      UART_IDLE:
        if (fallEdge && i_enable && (i_baud != '0) && !i_smStartPause) begin
          stateNext = UART_START;
          startGo   = 1'b1;
        end
      UART_START:
        if (halfHit) stateNext = rxSync ? UART_IDLE : UART_DATA;
      UART_DATA:
        if (fullHit) begin
          bitTick = 1'b1;
          if (bitIdx == 3'd7) stateNext = UART_STOP;
        end
      UART_STOP:
        if (fullHit) begin
          stopTick  = 1'b1;
          stateNext = UART_IDLE;
        end
      default: stateNext = UART_IDLE;
    endcase
    // Disable aborts any frame in flight; the partial byte is simply never committed
    if (!i_enable && (state != UART_IDLE)) begin
      stateNext = UART_IDLE;
      bitTick   = 1'b0;
      stopTick  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rxPrev        <= 1'b1;
      bRate         <= '0;
      cnt           <= '0;
      bitIdx        <= '0;
      shReg         <= '0;
      o_rxByte      <= '0;
      o_rxFull      <= 1'b0;
      o_errFrame    <= 1'b0;
      o_errOverrun  <= 1'b0;
      o_intURX      <= 1'b0;
      o_smNowPaused <= 1'b0;
    end else begin
      rxPrev        <= rxSync;
      o_smNowPaused <= i_smStartPause & (state == UART_IDLE);

      if (startGo) begin
        bRate  <= i_baud;
        bitIdx <= '0;
      end
      // Every state transition and every bit sample restarts the period count
      if (state == UART_IDLE || stateNext != state || bitTick) cnt <= '0;
      else                                                    cnt <= cnt + 16'd1;

      if (bitTick) begin
        shReg  <= {rxSync, shReg[UART_BYTE_W-1:1]};
        bitIdx <= bitIdx + 3'd1;
      end

      o_intURX <= stopTick & canLoad;
      if (stopTick && canLoad) begin
        o_rxByte <= shReg;
        o_rxFull <= 1'b1;
      end else if (i_rdAck) begin
        o_rxFull <= 1'b0;
      end

      o_errFrame   <= (o_errFrame   & ~i_errClr) | (stopTick & ~rxSync);
      o_errOverrun <= (o_errOverrun & ~i_errClr) | (stopTick & ~canLoad);
    end
  end
endmodule
